// File: rtl/arm_pkg.sv
// Shared ARM execute-stage definitions: condition-code encoding and NZCV flag bit positions.
package arm_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    // Bit positions within {N,Z,C,V}, matching the ALUFlags ordering
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_unit_if.sv
// Decoder/ALU <-> conditional-execution unit bundle; master drives the instruction, slave is cond_unit.
interface cond_unit_if;
    logic       in_valid;
    logic [3:0] Cond;
    logic [1:0] FlagW;
    logic       RegW;
    logic       MemW;
    logic       PCS;
    logic       NoWrite;
    logic [3:0] ALUFlags;
    logic       CarryIn;
    logic [3:0] Flags;
    logic       CondEx;
    logic       RegWrite;
    logic       MemWrite;
    logic       PCSrc;
    logic       out_valid;

    modport master (
        output in_valid, Cond, FlagW, RegW, MemW, PCS, NoWrite, ALUFlags,
        input  CarryIn, Flags, CondEx, RegWrite, MemWrite, PCSrc, out_valid
    );

    modport slave (
        input  in_valid, Cond, FlagW, RegW, MemW, PCS, NoWrite, ALUFlags,
        output CarryIn, Flags, CondEx, RegWrite, MemWrite, PCSrc, out_valid
    );
endinterface

// File: rtl/cond_check.sv
// Purely combinational ARM condition-field evaluator against the current NZCV flags.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            EQ: cond_ex = z;
            NE: cond_ex = ~z;
            CS: cond_ex = c;
            CC: cond_ex = ~c;
            MI: cond_ex = n;
            PL: cond_ex = ~n;
            VS: cond_ex = v;
            VC: cond_ex = ~v;
            HI: cond_ex = c & ~z;
            LS: cond_ex = ~c | z;
            GE: cond_ex = (n == v);
            LT: cond_ex = (n != v);
            GT: cond_ex = ~z & (n == v);
            LE: cond_ex = z | (n != v);
            AL: cond_ex = 1'b1;
            NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage flag register and write-enable gating. Optional perf counters
// (exec_cnt/skip_cnt) are built when COND_PERF_CNT_EN is defined.
module cond_unit
    import arm_pkg::*;
#(
    parameter bit         OUT_REG   = 1'b1,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    cond_unit_if.slave  bus
`ifdef COND_PERF_CNT_EN
    ,
    output logic [31:0] exec_cnt,
    output logic [31:0] skip_cnt
`endif
);

    logic [3:0] flags_q;
    logic       cond_pass;
    logic       cond_ex;
    logic       reg_write_d;
    logic       mem_write_d;
    logic       pc_src_d;

    cond_check u_cond_check (
        .cond    (bus.Cond),
        .flags   (flags_q),
        .cond_ex (cond_pass)
    );

    assign cond_ex     = bus.in_valid & cond_pass;
    assign reg_write_d = cond_ex & bus.RegW & ~bus.NoWrite;
    assign mem_write_d = cond_ex & bus.MemW;
    assign pc_src_d    = cond_ex & bus.PCS;

    assign bus.CondEx  = cond_ex;
    assign bus.Flags   = flags_q;
    assign bus.CarryIn = flags_q[FLAG_C];

    // N/Z and C/V update independently; a failed condition leaves both pairs untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= FLAGS_RST;
        end else if (cond_ex) begin
            if (bus.FlagW[1]) flags_q[FLAG_N:FLAG_Z] <= bus.ALUFlags[FLAG_N:FLAG_Z];
            if (bus.FlagW[0]) flags_q[FLAG_C:FLAG_V] <= bus.ALUFlags[FLAG_C:FLAG_V];
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic reg_write_q, mem_write_q, pc_src_q, out_valid_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    reg_write_q <= 1'b0;
                    mem_write_q <= 1'b0;
                    pc_src_q    <= 1'b0;
                    out_valid_q <= 1'b0;
                end else begin
                    reg_write_q <= reg_write_d;
                    mem_write_q <= mem_write_d;
                    pc_src_q    <= pc_src_d;
                    out_valid_q <= bus.in_valid;
                end
            end

            assign bus.RegWrite  = reg_write_q;
            assign bus.MemWrite  = mem_write_q;
            assign bus.PCSrc     = pc_src_q;
            assign bus.out_valid = out_valid_q;
        end else begin : g_out_comb
            assign bus.RegWrite  = reg_write_d;
            assign bus.MemWrite  = mem_write_d;
            assign bus.PCSrc     = pc_src_d;
            assign bus.out_valid = bus.in_valid;
        end
    endgenerate

`ifdef COND_PERF_CNT_EN
    // Free-running counters that wrap naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_cnt <= 32'd0;
            skip_cnt <= 32'd0;
        end else if (bus.in_valid) begin
            if (cond_pass) exec_cnt <= exec_cnt + 32'd1;
            else           skip_cnt <= skip_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed vector table, hand sequences and randomized model check.
module tb_cond_unit;
    import arm_pkg::*;

    localparam bit         OUT_REG   = 1'b1;
    localparam logic [3:0] FLAGS_RST = 4'b0000;

    typedef struct packed {
        logic       reset;
        logic       valid;
        logic [3:0] cond;
        logic [1:0] flagw;
        logic       regw;
        logic       memw;
        logic       pcs;
        logic       nowrite;
        logic [3:0] alu;
    } in_t;

    typedef struct packed {
        logic       condex;
        logic [3:0] flags_pre;
        logic       regwrite;
        logic       memwrite;
        logic       pcsrc;
        logic [3:0] flags_after;
    } exp_t;

    typedef struct packed {
        in_t  s;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] mflags;
    logic [31:0] mexec = 32'd0;
    logic [31:0] mskip = 32'd0;

    cond_unit_if bus ();

`ifdef COND_PERF_CNT_EN
    logic [31:0] exec_cnt, skip_cnt;
`endif

    cond_unit #(.OUT_REG(OUT_REG), .FLAGS_RST(FLAGS_RST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef COND_PERF_CNT_EN
        ,
        .exec_cnt (exec_cnt),
        .skip_cnt (skip_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference: ARM pairs each predicate (even code) with its negation (odd code)
    function automatic logic condPass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, r;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: r = z;
            3'd1: r = c;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = c && !z;
            3'd5: r = (n == v);
            3'd6: r = (n == v) && !z;
            default: r = 1'b1;
        endcase
        if (cond == 4'hF) return 1'b0;
        return cond[0] ? !r : r;
    endfunction

    function automatic exp_t makeExp(input in_t s, input logic [3:0] f);
        exp_t e;
        logic [3:0] nf;
        e.condex    = s.valid && condPass(s.cond, f);
        e.flags_pre = f;
        e.regwrite  = e.condex && s.regw && !s.nowrite;
        e.memwrite  = e.condex && s.memw;
        e.pcsrc     = e.condex && s.pcs;
        nf = f;
        if (e.condex && s.flagw[1]) nf[3:2] = s.alu[3:2];
        if (e.condex && s.flagw[0]) nf[1:0] = s.alu[1:0];
        e.flags_after = s.reset ? FLAGS_RST : nf;
        return e;
    endfunction

    function automatic vec_t mk(input logic v, input logic [3:0] cond, input logic [1:0] fw,
                                input logic rw, input logic mw, input logic pcs, input logic nw,
                                input logic [3:0] alu, input logic cx, input logic [3:0] fpre,
                                input logic erw, input logic emw, input logic epc,
                                input logic [3:0] fafter);
        vec_t t;
        t.s = '{reset: 1'b0, valid: v, cond: cond, flagw: fw, regw: rw, memw: mw,
                pcs: pcs, nowrite: nw, alu: alu};
        t.e = '{condex: cx, flags_pre: fpre, regwrite: erw, memwrite: emw, pcsrc: epc,
                flags_after: fafter};
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input in_t s);
        @(negedge clk);
        reset        = s.reset;
        bus.in_valid = s.valid;
        bus.Cond     = s.cond;
        bus.FlagW    = s.flagw;
        bus.RegW     = s.regw;
        bus.MemW     = s.memw;
        bus.PCS      = s.pcs;
        bus.NoWrite  = s.nowrite;
        bus.ALUFlags = s.alu;
    endtask

    // Combinational outputs are checked mid-cycle, registered ones #1 after the edge
    task automatic checkOutput(input in_t s, input exp_t e, input string tag);
        #1;
        check({tag, ".CondEx"},  {31'd0, bus.CondEx},  {31'd0, e.condex});
        check({tag, ".CarryIn"}, {31'd0, bus.CarryIn}, {31'd0, e.flags_pre[1]});
        check({tag, ".FlagsPre"}, {28'd0, bus.Flags},  {28'd0, e.flags_pre});
        if (!OUT_REG) begin
            check({tag, ".RegWrite"}, {31'd0, bus.RegWrite}, {31'd0, e.regwrite});
            check({tag, ".MemWrite"}, {31'd0, bus.MemWrite}, {31'd0, e.memwrite});
            check({tag, ".PCSrc"},    {31'd0, bus.PCSrc},    {31'd0, e.pcsrc});
            check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, s.valid});
        end
        @(posedge clk);
        #1;
        if (OUT_REG) begin
            check({tag, ".RegWrite"}, {31'd0, bus.RegWrite}, {31'd0, e.regwrite & ~s.reset});
            check({tag, ".MemWrite"}, {31'd0, bus.MemWrite}, {31'd0, e.memwrite & ~s.reset});
            check({tag, ".PCSrc"},    {31'd0, bus.PCSrc},    {31'd0, e.pcsrc & ~s.reset});
            check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, s.valid & ~s.reset});
        end
        check({tag, ".Flags"}, {28'd0, bus.Flags}, {28'd0, e.flags_after});
        if (s.reset) begin
            mexec = 32'd0;
            mskip = 32'd0;
        end else if (s.valid && e.condex) begin
            mexec = mexec + 32'd1;
        end else if (s.valid) begin
            mskip = mskip + 32'd1;
        end
`ifdef COND_PERF_CNT_EN
        check({tag, ".exec_cnt"}, exec_cnt, mexec);
        check({tag, ".skip_cnt"}, skip_cnt, mskip);
`endif
    endtask

    task automatic runModel(input in_t s, input string tag);
        exp_t e;
        e = makeExp(s, mflags);
        applyStimulus(s);
        checkOutput(s, e, tag);
        mflags = e.flags_after;
    endtask

    initial begin
        vec_t       tbl[$];
        in_t        s;
        exp_t       e;
        logic [15:0] sweep_exp;
        bit         cx;

        reset = 1'b1;
        bus.in_valid = 1'b0; bus.Cond = 4'h0; bus.FlagW = 2'b00; bus.RegW = 1'b0;
        bus.MemW = 1'b0; bus.PCS = 1'b0; bus.NoWrite = 1'b0; bus.ALUFlags = 4'h0;
        repeat (2) @(posedge clk);

        // Checked reset cycle establishes a known starting point
        s = '0;
        s.reset = 1'b1;
        e = '{condex: 1'b0, flags_pre: FLAGS_RST, regwrite: 1'b0, memwrite: 1'b0,
              pcsrc: 1'b0, flags_after: FLAGS_RST};
        applyStimulus(s);
        checkOutput(s, e, "reset");

        //          v  cond  fw     rw mw pc nw alu      cx pre      rw mw pc after
        tbl.push_back(mk(1, 4'h0, 2'b00, 1, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'hE, 2'b11, 1, 0, 0, 1, 4'b0110, 1, 4'b0000, 0, 0, 0, 4'b0110));
        tbl.push_back(mk(1, 4'h0, 2'b00, 0, 0, 1, 0, 4'b0000, 1, 4'b0110, 0, 0, 1, 4'b0110));
        tbl.push_back(mk(1, 4'hE, 2'b01, 0, 0, 0, 0, 4'b0000, 1, 4'b0110, 0, 0, 0, 4'b0100));
        tbl.push_back(mk(1, 4'h1, 2'b11, 0, 1, 0, 0, 4'b1011, 0, 4'b0100, 0, 0, 0, 4'b0100));
        tbl.push_back(mk(1, 4'hE, 2'b11, 0, 0, 0, 0, 4'b0000, 1, 4'b0100, 0, 0, 0, 4'b0000));
        tbl.push_back(mk(1, 4'hE, 2'b10, 0, 0, 0, 0, 4'b1111, 1, 4'b0000, 0, 0, 0, 4'b1100));
        tbl.push_back(mk(1, 4'hE, 2'b01, 0, 0, 0, 0, 4'b0010, 1, 4'b1100, 0, 0, 0, 4'b1110));
        tbl.push_back(mk(1, 4'hE, 2'b11, 0, 0, 0, 0, 4'b1001, 1, 4'b1110, 0, 0, 0, 4'b1001));
        // With N=1,Z=0,C=0,V=1 the sixteen conditions resolve to this bit pattern (bit i = cond i)
        sweep_exp = 16'h565A;
        for (int i = 0; i < 16; i++) begin
            cx = sweep_exp[i];
            tbl.push_back(mk(1, 4'(i), 2'b00, 1, 0, 0, 0, 4'b1111, cx, 4'b1001, cx, 0, 0, 4'b1001));
        end
        tbl.push_back(mk(0, 4'hE, 2'b11, 1, 1, 1, 0, 4'b0110, 0, 4'b1001, 0, 0, 0, 4'b1001));
        tbl.push_back(mk(1, 4'hE, 2'b00, 1, 1, 1, 0, 4'b0000, 1, 4'b1001, 1, 1, 1, 4'b1001));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].s);
            checkOutput(tbl[i].s, tbl[i].e, $sformatf("vec%0d", i));
        end

        // Reset on the same edge as a flag-writing instruction discards the update
        mflags = 4'b1001;
        s = '{reset: 1'b0, valid: 1'b1, cond: 4'hE, flagw: 2'b11, regw: 1'b0, memw: 1'b0,
              pcs: 1'b0, nowrite: 1'b0, alu: 4'b1111};
        runModel(s, "set1111");
        s.reset = 1'b1;
        s.regw  = 1'b1;
        runModel(s, "midReset");

        s = '0;
        s.valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s.cond = (i < 3) ? 4'hE : 4'hF;
            runModel(s, $sformatf("perf%0d", i));
        end
`ifdef COND_PERF_CNT_EN
        check("perf.exec3", exec_cnt, 32'd3);
        check("perf.skip2", skip_cnt, 32'd2);
`endif
        s = '0;
        s.reset = 1'b1;
        runModel(s, "perfReset");
`ifdef COND_PERF_CNT_EN
        check("perf.execClr", exec_cnt, 32'd0);
        check("perf.skipClr", skip_cnt, 32'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            s.reset   = ($urandom_range(0, 29) == 0);
            s.valid   = ($urandom_range(0, 3) != 0);
            s.cond    = 4'($urandom);
            s.flagw   = 2'($urandom);
            s.regw    = 1'($urandom);
            s.memw    = 1'($urandom);
            s.pcs     = 1'($urandom);
            s.nowrite = 1'($urandom);
            s.alu     = 4'($urandom);
            runModel(s, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Conditional-execution and flag-register block for the 32-bit ARM core; consumer end of the ALU flag interface.
- Holds the architectural NZCV flags and evaluates each instruction's 4-bit condition field against them.
- Gates register, memory and PC write enables, and returns CarryIn to the ALU for ADC/SBC/RSC.
- Sits between the decoder and the writeback/memory/PC-select paths in the execute stage.

Parameters:
- OUT_REG, 1, 1 = gated enables and out_valid registered (latency 1); 0 = combinational (latency 0)
- FLAGS_RST, 4'b0000, reset value of the {N,Z,C,V} flag register

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  instruction present in execute this cycle
- Cond  input  4  instruction condition field [31:28]
- FlagW  input  2  bit1: update N,Z; bit0: update C,V (from the S bit and the op class)
- RegW  input  1  decoder register-write request
- MemW  input  1  decoder memory-write request
- PCS  input  1  decoder PC-write request (branch or Rd==PC)
- NoWrite  input  1  compare/test op (TST/TEQ/CMP/CMN); suppresses register write
- ALUFlags  input  4  {N,Z,C,V} from the ALU, same cycle as in_valid
- CarryIn  output  1  current C flag, to ALU
- Flags  output  4  architectural {N,Z,C,V} register
- CondEx  output  1  condition passed this cycle (combinational, unregistered)
- RegWrite  output  1  gated register write
- MemWrite  output  1  gated memory write
- PCSrc  output  1  gated PC select
- out_valid  output  1  qualifies RegWrite/MemWrite/PCSrc

Behaviour:
Reset
- Synchronous and active-high, on the clk edge.
- Flags <= FLAGS_RST.
- Output registers (OUT_REG=1) clear to 0: RegWrite, MemWrite, PCSrc, out_valid.
- Reset dominates any in_valid on the same edge: the flag update is discarded.
- CarryIn = Flags[1] always; after reset it equals FLAGS_RST[1].

Condition evaluation (combinational on the Flags register; Cond -> CondEx)
- 0000 EQ: Z
- 0001 NE: ~Z
- 0010 CS: C
- 0011 CC: ~C
- 0100 MI: N
- 0101 PL: ~N
- 0110 VS: V
- 0111 VC: ~V
- 1000 HI: C & ~Z
- 1001 LS: ~C | Z
- 1010 GE: N == V
- 1011 LT: N != V
- 1100 GT: ~Z & (N == V)
- 1101 LE: Z | (N != V)
- 1110 AL: 1
- 1111: 0 (never; treated as NV)
- CondEx is forced to 0 when in_valid = 0.

Enable gating
- RegWrite = CondEx & RegW & ~NoWrite
- MemWrite = CondEx & MemW
- PCSrc = CondEx & PCS
- OUT_REG=1: these three and out_valid = in_valid are sampled at the edge and appear the next cycle.
- OUT_REG=0: they are driven directly, and out_valid = in_valid.

Flag update (independent of OUT_REG)
- At the edge ending cycle t, if in_valid & CondEx:
  - FlagW[1] -> Flags[3:2] <= ALUFlags[3:2]
  - FlagW[0] -> Flags[1:0] <= ALUFlags[1:0]
- Any other case: Flags hold.
- An instruction in cycle t+1 sees the flags written in cycle t. No forwarding is needed; back-to-back CMP then BEQ is correct.
- A failed condition never alters flags, even with FlagW=2'b11.
- CarryIn reflects the pre-update C, so an ADCS sees the old carry in the same cycle it produces the new one.
- in_valid=0 with nonzero FlagW: no update.

Optional Feature:
- Macro COND_PERF_CNT_EN.
- Defined: adds outputs exec_cnt[31:0] and skip_cnt[31:0], both reset to 0.
  - exec_cnt increments on in_valid & CondEx.
  - skip_cnt increments on in_valid & ~CondEx.
  - Both wrap from 32'hFFFF_FFFF to 0; no saturation.
  - Reset has priority over increment.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package arm_pkg holds:
  - cond_e enum for the 16 condition codes (EQ..AL, NV)
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0 (same ordering as ALUFlags)
- One sub-module: cond_check (purely combinational; Cond + Flags -> CondEx).
- The flag register, output pipeline and counters stay in cond_unit.

Test Plan:
- Reset with FLAGS_RST=0, then in_valid with Cond=EQ, RegW=1 -> CondEx=0, RegWrite=0 (after 1 cycle when OUT_REG=1), Flags=4'b0000.
- CMP cycle: Cond=AL, FlagW=11, NoWrite=1, RegW=1, ALUFlags=4'b0110 -> RegWrite=0, Flags=4'b0110 next cycle. Following cycle BEQ (Cond=0000, PCS=1) -> PCSrc=1.
- With Flags=4'b1001 (N=1, V=1): sweep all 16 Cond values with RegW=1 -> CondEx matches the table (GE=1, LT=0, GT=1, LE=0, NV=0).
- Conditional failure: Flags=0100, Cond=NE, FlagW=11, ALUFlags=1011 -> Flags remain 0100, MemWrite=0.
- Partial update: Flags=0000, Cond=AL, FlagW=10, ALUFlags=1111 -> Flags=1100 and CarryIn stays 0. Then FlagW=01, ALUFlags=0010 -> Flags=1110, CarryIn=1.
- Reset mid-stream: in_valid=1, AL, FlagW=11, ALUFlags=1111 with reset=1 on the same edge -> Flags=FLAGS_RST and out_valid=0 next cycle. With COND_PERF_CNT_EN, 3 exec + 2 skip -> exec_cnt=3, skip_cnt=2, and reset clears both.
